// File: rtl/pe_array_pkg.sv
// Shared types and helpers for the PE array: link word layout and feeder FSM states.
package pe_array_pkg;

  localparam int WORD_W   = 25;
  localparam int DATA_W   = 8;
  localparam int PSUM_LSB = 8;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } feeder_state_t;

  function automatic logic [WORD_W-1:0] pack_word(input logic [DATA_W-1:0]          data,
                                                  input logic [WORD_W-PSUM_LSB-1:0] psum);
    return {psum, data};
  endfunction

endpackage

// File: rtl/feeder_fifo.sv
// Synchronous show-ahead FIFO with registered occupancy; reset flushes pointers only.
module feeder_fifo
  import pe_array_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      occ;
  logic             do_push;
  logic             do_pop;

  assign full    = (occ == (AW+1)'(DEPTH));
  assign empty   = (occ == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   occ <= occ + (AW+1)'(1);
        2'b01:   occ <= occ - (AW+1)'(1);
        default: occ <= occ;
      endcase
    end
  end

endmodule

// File: rtl/pe_edge_feeder.sv
// Left-edge feeder: buffers activation vectors and drives each PE row with a row-skewed word.
// Optional macro FEEDER_PERF_EN adds the bubble_cnt performance counter port.
module pe_edge_feeder #(
  parameter int ROWS   = 4,
  parameter int DATA_W = 8,
  parameter int WORD_W = 25,
  parameter int DEPTH  = 16,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [CNT_W-1:0]         vec_count,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [ROWS*DATA_W-1:0]   in_data,
  output logic [ROWS*WORD_W-1:0]   feed_out,
  output logic [ROWS-1:0]          feed_valid,
  output logic                     workstate,
  output logic                     busy,
  output logic                     done
`ifdef FEEDER_PERF_EN
  ,
  output logic [CNT_W-1:0]         bubble_cnt
`endif
);

  import pe_array_pkg::*;

  localparam int DW_ALL = ROWS * DATA_W;

  feeder_state_t     state;
  feeder_state_t     state_next;
  logic [CNT_W-1:0]  remaining;
  logic [CNT_W-1:0]  drain_cnt;
  logic              zero_done;
  logic              fifo_full;
  logic              fifo_empty;
  logic              push;
  logic              pop;
  logic [DW_ALL-1:0] fifo_rd_data;
  logic              start_ok;
  logic              last_pop;
  logic              drain_end;

  assign in_ready  = !fifo_full;
  assign push      = in_valid && in_ready;
  assign pop       = (state == RUN) && !fifo_empty;
  assign start_ok  = start && (state == IDLE);
  assign last_pop  = pop && (remaining == CNT_W'(1));
  assign drain_end = (state == DRAIN) && (drain_cnt == '0);
  assign busy      = (state != IDLE);
  assign done      = drain_end || zero_done;

  feeder_fifo #(
    .WIDTH (DW_ALL),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (push),
    .wr_data (in_data),
    .pop     (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_ok && (vec_count != '0)) state_next = RUN;
      RUN:     if (last_pop) state_next = DRAIN;
      DRAIN:   if (drain_end) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // workstate covers RUN/DRAIN but lags one cycle so it lines up with lane-0 data
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      remaining <= '0;
      drain_cnt <= '0;
      zero_done <= 1'b0;
      workstate <= 1'b0;
    end else begin
      state     <= state_next;
      zero_done <= start_ok && (vec_count == '0);
      workstate <= (state != IDLE) && (state_next != IDLE);
      if (start_ok)  remaining <= vec_count;
      else if (pop)  remaining <= remaining - CNT_W'(1);
      if (last_pop)  drain_cnt <= CNT_W'(ROWS - 1);
      else if ((state == DRAIN) && (drain_cnt != '0)) drain_cnt <= drain_cnt - CNT_W'(1);
    end
  end

`ifdef FEEDER_PERF_EN
  always_ff @(posedge clk) begin
    if (reset)                                          bubble_cnt <= '0;
    else if (start_ok)                                  bubble_cnt <= '0;
    else if ((state == RUN) && !pop && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + CNT_W'(1);
  end
`endif

  // p0: common output register; bubbles load zero so idle lanes carry all-zero words
  logic [DW_ALL-1:0] vec_p0;
  logic              vld_p0;

  always_ff @(posedge clk) begin
    if (reset) begin
      vec_p0 <= '0;
      vld_p0 <= 1'b0;
    end else begin
      vec_p0 <= pop ? fifo_rd_data : '0;
      vld_p0 <= pop;
    end
  end

  // p1: lane r adds an r-deep delay chain behind p0
  for (genvar r = 0; r < ROWS; r++) begin : g_lane
    logic [DATA_W-1:0] lane_dat;
    logic              lane_vld;

    if (r == 0) begin : g_direct
      assign lane_dat = vec_p0[0 +: DATA_W];
      assign lane_vld = vld_p0;
    end else begin : g_skew
      logic [DATA_W-1:0] dat_p1 [r];
      logic              vld_p1 [r];

      always_ff @(posedge clk) begin
        if (reset) begin
          for (int k = 0; k < r; k++) begin
            dat_p1[k] <= '0;
            vld_p1[k] <= 1'b0;
          end
        end else begin
          dat_p1[0] <= vec_p0[r*DATA_W +: DATA_W];
          vld_p1[0] <= vld_p0;
          for (int k = 1; k < r; k++) begin
            dat_p1[k] <= dat_p1[k-1];
            vld_p1[k] <= vld_p1[k-1];
          end
        end
      end

      assign lane_dat = dat_p1[r-1];
      assign lane_vld = vld_p1[r-1];
    end

    assign feed_out[r*WORD_W +: WORD_W] = pack_word(lane_dat, '0);
    assign feed_valid[r]                = lane_vld;
  end

endmodule
